change_dispenser: RTL and testbench
===================================

# change_dispenser

Downstream actuator controller for the vending machine FSM. Captures the one-cycle soda/change result (soda strobe plus 3-bit change code in 5-cent units) and converts it into timed eject pulses for the soda chute and the dime/nickel hoppers. Emits pulses one at a time with fixed widths and gaps. Reports busy, completion, dropped requests and hopper faults to the system controller.

## Interface
- PULSE_CYCLES, 4: width of every eject pulse in clk_i cycles; legal range 1 to 255.
- GAP_CYCLES, 2: idle cycles between consecutive pulses; legal range 1 to 255.
- clk_i  input  1  system clock, rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
- soda_i  input  1  one-cycle request strobe from the vending FSM.
- change_i  input  3  change code, valid with soda_i: 000=0c, 001=5c, 010=10c, 011=15c, 100=20c; 101–111 are illegal.
- nickel_empty_i  input  1  nickel hopper empty sensor, level.
- dime_empty_i  input  1  dime hopper empty sensor, level.
- clear_i  input  1  fault clear, level; effective only in FAULT.
- soda_eject_o  output  1  soda chute actuator.
- nickel_eject_o  output  1  nickel hopper actuator.
- dime_eject_o  output  1  dime hopper actuator.
- busy_o  output  1  high whenever state != IDLE.
- done_o  output  1  one-cycle completion pulse.
- req_lost_o  output  1  one-cycle pulse when a soda_i strobe arrives while not IDLE.
- fault_o  output  1  high in FAULT.

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE, rem resets to 0, and the timer resets to 0.
- rem is a 3-bit register holding the outstanding change in nickels. It is loaded with change_i on acceptance.
- State IDLE:
  - soda_i=1 with a legal code goes to EJECT_SODA and loads rem.
  - soda_i=1 with an illegal code goes to FAULT. No soda is ejected.
- State EJECT_SODA: soda_eject_o=1 for PULSE_CYCLES cycles. Then:
  - rem=0 goes to DONE.
  - Otherwise goes to GAP.
- State GAP: all ejects are 0 for GAP_CYCLES cycles. On the last GAP cycle, select a coin from the hopper sensors sampled that cycle:
  - rem>=2 and !dime_empty_i: dime. Go to EJECT_COIN and subtract 2 from rem.
  - Else, if !nickel_empty_i: nickel. Go to EJECT_COIN and subtract 1 from rem.
  - Else go to FAULT; rem is kept.
- State EJECT_COIN: the selected eject output is 1 for PULSE_CYCLES cycles. Then:
  - rem=0 goes to DONE.
  - Otherwise goes to GAP.
- State DONE: done_o=1 for one cycle, then IDLE.
- State FAULT: fault_o=1 and all ejects are 0. Stays in FAULT until clear_i=1, then goes to IDLE with rem cleared. No partial refund is reattempted.
- The greedy order is dimes first, then nickels. An empty dime hopper is covered by two nickels.
- Any soda_i strobe while not IDLE is ignored and produces req_lost_o for one cycle, starting the next cycle.
- Only one eject output is ever high at a time.

## Timing
- A strobe sampled at the edge ending cycle N puts the first soda pulse on cycles N+1 through N+PULSE_CYCLES.
- With the defaults, change 100 with both hoppers full gives:
  - soda N+1..N+4
  - gap N+5..N+6
  - dime N+7..N+10
  - gap N+11..N+12
  - dime N+13..N+16
  - done N+17
  - IDLE at N+18, when a new request can be accepted
- busy_o is high from N+1 through N+17.
- Total latency to done_o is 1 + P·(1+k) + G·k cycles, where k is the number of coins, P is PULSE_CYCLES and G is GAP_CYCLES. There is no trailing gap after the last pulse.
- Change 000 with the defaults gives soda N+1..N+4 and done N+5.
- Fault on illegal code: fault_o rises at N+1.
- Fault on empty hoppers: fault_o rises the cycle after the last GAP cycle.
- Fault clear: clear_i sampled high in FAULT puts the block in IDLE next cycle, with fault_o=0.
- Reset mid-operation: outputs drop asynchronously and any active pulse is truncated.
- Hopper sensors are sampled only on the last GAP cycle. A hopper emptying during a pulse does not abort that pulse.

## Structure
- Package vending_pkg holds the items shared with the vending FSM:
  - change code localparams CHG_0, CHG_5, CHG_10, CHG_15, CHG_20
  - the dispenser state enum dispense_state_e (IDLE, EJECT_SODA, GAP, EJECT_COIN, DONE, FAULT)
  - coin select enum coin_e (COIN_NICKEL, COIN_DIME)
- Sub-module pulse_timer:
  - 8-bit loadable down-counter
  - load_i/len_i inputs and expired_o output
  - shared by the pulse and gap phases
  - its reset style is the same as this block's

## Test plan
- Reset, then strobe change 000: soda_eject_o high for 4 cycles, done_o on cycle 5, no coin pulses.
- Change 100, both hoppers full: exactly two 4-cycle dime pulses separated by 2-cycle gaps; done_o at N+17.
- Change 011, dime_empty_i=1: three nickel pulses; rem reaches 0; dime_eject_o never asserted.
- Change 001, nickel_empty_i=1: soda pulse, then fault_o=1 after the gap. Assert clear_i: IDLE next cycle, busy_o=0.
- Change 101: fault_o at N+1, no eject pulses. A strobe during a busy sequence gives a one-cycle req_lost_o and the sequence is unchanged.
- Drive rst_ni low mid dime pulse: all outputs 0 immediately. After release, the block accepts a new request normally.

Source files
------------

// File: rtl/vending_pkg.sv
// Items shared between the vending FSM and the change dispenser:
// change codes, dispenser states and coin selection.
package vending_pkg;

  localparam logic [2:0] CHG_0  = 3'd0;
  localparam logic [2:0] CHG_5  = 3'd1;
  localparam logic [2:0] CHG_10 = 3'd2;
  localparam logic [2:0] CHG_15 = 3'd3;
  localparam logic [2:0] CHG_20 = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    EJECT_SODA,
    GAP,
    EJECT_COIN,
    DONE,
    FAULT
  } dispense_state_e;

  typedef enum logic {
    COIN_NICKEL,
    COIN_DIME
  } coin_e;

  function automatic logic chg_legal(input logic [2:0] code);
    return code inside {CHG_0, CHG_5, CHG_10, CHG_15, CHG_20};
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable 8-bit down-counter timing the eject pulses and the gaps between them.
// expired_o marks the final cycle of the loaded length.
module pulse_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] len_i,
  output logic       expired_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= len_i;
    end else if (cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign expired_o = (cnt_q == 8'd1);

endmodule

// File: rtl/change_dispenser.sv
// Turns a one-cycle soda/change result into timed soda, dime and nickel eject
// pulses, one at a time, with busy/done/lost-request/fault reporting.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       soda_i,
  input  logic [2:0] change_i,
  input  logic       nickel_empty_i,
  input  logic       dime_empty_i,
  input  logic       clear_i,
  output logic       soda_eject_o,
  output logic       nickel_eject_o,
  output logic       dime_eject_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       req_lost_o,
  output logic       fault_o
);

  dispense_state_e state_q, state_d;
  logic [2:0]      rem_q, rem_d;
  coin_e           coin_q, coin_d;
  logic            tmr_load;
  logic [7:0]      tmr_len;
  logic            tmr_expired;

  pulse_timer u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (tmr_load),
    .len_i     (tmr_len),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    coin_d  = coin_q;
    unique case (state_q)
      IDLE: begin
        if (soda_i) begin
          if (chg_legal(change_i)) begin
            state_d = EJECT_SODA;
            rem_d   = change_i;
          end else begin
            state_d = FAULT;
          end
        end
      end
      EJECT_SODA, EJECT_COIN: begin
        if (tmr_expired) begin
          if (rem_q == CHG_0) state_d = DONE;
          else                state_d = GAP;
        end
      end
      GAP: begin
        // Hopper sensors only matter on the last gap cycle; greedy dimes first.
        if (tmr_expired) begin
          if (rem_q >= CHG_10 && !dime_empty_i) begin
            coin_d  = COIN_DIME;
            rem_d   = rem_q - CHG_10;
            state_d = EJECT_COIN;
          end else if (!nickel_empty_i) begin
            coin_d  = COIN_NICKEL;
            rem_d   = rem_q - CHG_5;
            state_d = EJECT_COIN;
          end else begin
            state_d = FAULT;
          end
        end
      end
      DONE: state_d = IDLE;
      FAULT: begin
        if (clear_i) begin
          state_d = IDLE;
          rem_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tmr_load = (state_d != state_q) &&
                    (state_d inside {EJECT_SODA, GAP, EJECT_COIN});
  assign tmr_len  = (state_d == GAP) ? 8'(GAP_CYCLES) : 8'(PULSE_CYCLES);

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      rem_q          <= '0;
      coin_q         <= COIN_NICKEL;
      soda_eject_o   <= 1'b0;
      nickel_eject_o <= 1'b0;
      dime_eject_o   <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      req_lost_o     <= 1'b0;
      fault_o        <= 1'b0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      coin_q         <= coin_d;
      soda_eject_o   <= (state_d == EJECT_SODA);
      nickel_eject_o <= (state_d == EJECT_COIN) && (coin_d == COIN_NICKEL);
      dime_eject_o   <= (state_d == EJECT_COIN) && (coin_d == COIN_DIME);
      busy_o         <= (state_d != IDLE);
      done_o         <= (state_d == DONE);
      req_lost_o     <= soda_i && (state_q != IDLE);
      fault_o        <= (state_d == FAULT);
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: table of requests with hand-derived pulse counts
// and timings, plus reset and lost-request sequences.
module tb_change_dispenser;

  localparam int P = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       soda_i = 1'b0;
  logic [2:0] change_i = 3'd0;
  logic       nickel_empty_i = 1'b0;
  logic       dime_empty_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       soda_eject_o, nickel_eject_o, dime_eject_o;
  logic       busy_o, done_o, req_lost_o, fault_o;

  always #5 clk_i = ~clk_i;

  change_dispenser #(.PULSE_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .soda_i         (soda_i),
    .change_i       (change_i),
    .nickel_empty_i (nickel_empty_i),
    .dime_empty_i   (dime_empty_i),
    .clear_i        (clear_i),
    .soda_eject_o   (soda_eject_o),
    .nickel_eject_o (nickel_eject_o),
    .dime_eject_o   (dime_eject_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .req_lost_o     (req_lost_o),
    .fault_o        (fault_o)
  );

  typedef struct {
    logic [2:0] chg;
    logic       nempty;
    logic       dempty;
    int         inj;
    int         soda_cyc;
    int         dimes;
    int         nickels;
    int         done_at;
    int         fault_at;
    int         lost;
  } vec_t;

  typedef struct {
    int soda_cyc;
    int dimes;
    int nickels;
    int done_at;
    int fault_at;
    int lost;
  } res_t;

  vec_t vecs[14];
  res_t exp_q[$];
  int   passed = 0;
  int   total = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int outs();
    return int'({soda_eject_o, nickel_eject_o, dime_eject_o, busy_o,
                 done_o, req_lost_o, fault_o});
  endfunction

  task automatic run_seq(input vec_t v, input int idx);
    res_t e, a, r;
    int   run_s, run_n, run_d;
    bit   width_ok, onehot_ok, busy_ok, fin;
    logic ps, pn, pd;
    e = '{v.soda_cyc, v.dimes, v.nickels, v.done_at, v.fault_at, v.lost};
    exp_q.push_back(e);
    a = '{0, 0, 0, 0, 0, 0};
    run_s = 0; run_n = 0; run_d = 0;
    ps = 1'b0; pn = 1'b0; pd = 1'b0;
    width_ok = 1'b1; onehot_ok = 1'b1; busy_ok = 1'b1; fin = 1'b0;
    nickel_empty_i = v.nempty;
    dime_empty_i   = v.dempty;
    @(negedge clk_i);
    soda_i = 1'b1; change_i = v.chg;
    @(negedge clk_i);
    soda_i = 1'b0; change_i = 3'd0;
    for (int off = 1; off <= 80; off++) begin
      a.soda_cyc += int'(soda_eject_o);
      a.lost     += int'(req_lost_o);
      if (dime_eject_o && !pd) a.dimes++;
      if (nickel_eject_o && !pn) a.nickels++;
      if (ps && !soda_eject_o && run_s != P) width_ok = 1'b0;
      if (pn && !nickel_eject_o && run_n != P) width_ok = 1'b0;
      if (pd && !dime_eject_o && run_d != P) width_ok = 1'b0;
      run_s = soda_eject_o ? run_s + 1 : 0;
      run_n = nickel_eject_o ? run_n + 1 : 0;
      run_d = dime_eject_o ? run_d + 1 : 0;
      ps = soda_eject_o; pn = nickel_eject_o; pd = dime_eject_o;
      if (int'(soda_eject_o) + int'(nickel_eject_o) + int'(dime_eject_o) > 1)
        onehot_ok = 1'b0;
      if (!busy_o) busy_ok = 1'b0;
      if (done_o) begin a.done_at = off; fin = 1'b1; end
      if (fault_o) begin a.fault_at = off; fin = 1'b1; end
      if (fin) break;
      if (off == v.inj) begin soda_i = 1'b1; change_i = 3'd0; end
      else soda_i = 1'b0;
      @(negedge clk_i);
    end
    soda_i = 1'b0;
    check($sformatf("v%0d_finished", idx), int'(fin), 1);
    r = exp_q.pop_front();
    check($sformatf("v%0d_soda_cycles", idx), a.soda_cyc, r.soda_cyc);
    check($sformatf("v%0d_dime_pulses", idx), a.dimes, r.dimes);
    check($sformatf("v%0d_nickel_pulses", idx), a.nickels, r.nickels);
    check($sformatf("v%0d_done_at", idx), a.done_at, r.done_at);
    check($sformatf("v%0d_fault_at", idx), a.fault_at, r.fault_at);
    check($sformatf("v%0d_req_lost", idx), a.lost, r.lost);
    check($sformatf("v%0d_pulse_width", idx), int'(width_ok), 1);
    check($sformatf("v%0d_onehot", idx), int'(onehot_ok), 1);
    check($sformatf("v%0d_busy", idx), int'(busy_ok), 1);
    if (a.fault_at != 0) begin
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      check($sformatf("v%0d_clear_fault", idx), int'(fault_o), 0);
    end else begin
      @(negedge clk_i);
      check($sformatf("v%0d_done_width", idx), int'(done_o), 0);
    end
    check($sformatf("v%0d_idle_busy", idx), int'(busy_o), 0);
    nickel_empty_i = 1'b0;
    dime_empty_i   = 1'b0;
  endtask

  initial begin
    bit seen;
    //              chg   ne    de   inj soda d  n  done flt lost
    vecs[0]  = '{3'd0, 1'b0, 1'b0, 0,  4, 0, 0,  5,  0, 0};
    vecs[1]  = '{3'd4, 1'b0, 1'b0, 0,  4, 2, 0, 17,  0, 0};
    vecs[2]  = '{3'd3, 1'b0, 1'b1, 0,  4, 0, 3, 23,  0, 0};
    vecs[3]  = '{3'd3, 1'b0, 1'b0, 0,  4, 1, 1, 17,  0, 0};
    vecs[4]  = '{3'd1, 1'b0, 1'b0, 0,  4, 0, 1, 11,  0, 0};
    vecs[5]  = '{3'd2, 1'b0, 1'b1, 0,  4, 0, 2, 17,  0, 0};
    vecs[6]  = '{3'd2, 1'b1, 1'b0, 0,  4, 1, 0, 11,  0, 0};
    vecs[7]  = '{3'd1, 1'b1, 1'b0, 0,  4, 0, 0,  0,  7, 0};
    vecs[8]  = '{3'd5, 1'b0, 1'b0, 0,  0, 0, 0,  0,  1, 0};
    vecs[9]  = '{3'd7, 1'b0, 1'b0, 0,  0, 0, 0,  0,  1, 0};
    vecs[10] = '{3'd4, 1'b1, 1'b1, 0,  4, 0, 0,  0,  7, 0};
    vecs[11] = '{3'd3, 1'b1, 1'b0, 0,  4, 1, 0,  0, 13, 0};
    vecs[12] = '{3'd4, 1'b0, 1'b0, 3,  4, 2, 0, 17,  0, 1};
    vecs[13] = '{3'd3, 1'b0, 1'b1, 10, 4, 0, 3, 23,  0, 1};

    @(negedge clk_i);
    @(negedge clk_i);
    check("reset_outputs", outs(), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_reset_outputs", outs(), 0);

    for (int i = 0; i < 14; i++) run_seq(vecs[i], i);

    // Reset in the middle of a dime pulse, then a normal request.
    @(negedge clk_i);
    soda_i = 1'b1; change_i = 3'd4;
    @(negedge clk_i);
    soda_i = 1'b0; change_i = 3'd0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dime_eject_o) begin seen = 1'b1; break; end
      @(negedge clk_i);
    end
    check("rst_mid_dime_seen", int'(seen), 1);
    #2 rst_ni = 1'b0;
    #1 check("rst_mid_outputs", outs(), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_seq(vecs[0], 100);
    run_seq(vecs[1], 101);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
